// File: rtl/filter_pkg.sv
// filter_pkg: FSM states, production low-pass coefficient ROM and width helpers
// shared by filter_core_mc.
package filter_pkg;

   typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

   localparam int MAX_TAPS = 64;

   localparam logic signed [15:0] LP_COEFS [MAX_TAPS] = '{
      16'sd0,    -16'sd2,   -16'sd5,   -16'sd9,   -16'sd12,  -16'sd13,  -16'sd10,  16'sd0,
      16'sd18,   16'sd43,   16'sd72,   16'sd101,  16'sd124,  16'sd134,  16'sd124,  16'sd87,
      16'sd17,   -16'sd86,  -16'sd218, -16'sd367, -16'sd514, -16'sd634, -16'sd698, -16'sd678,
      -16'sd548, -16'sd290, 16'sd107,  16'sd641,  16'sd1290, 16'sd2018, 16'sd2770, 16'sd3485,
      16'sd3485, 16'sd2770, 16'sd2018, 16'sd1290, 16'sd641,  16'sd107,  -16'sd290, -16'sd548,
      -16'sd678, -16'sd698, -16'sd634, -16'sd514, -16'sd367, -16'sd218, -16'sd86,  16'sd17,
      16'sd87,   16'sd124,  16'sd134,  16'sd124,  16'sd101,  16'sd72,   16'sd43,   16'sd18,
      16'sd0,    -16'sd10,  -16'sd13,  -16'sd12,  -16'sd9,   -16'sd5,   -16'sd2,   16'sd0
   };

   function automatic int acc_w(input int coef_w, input int taps);
      return coef_w + $clog2(taps) + 1;
   endfunction

   function automatic int ch_w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/filter_core_mc_if.sv
// filter_core_mc_if: channel-tagged result stream, valid/ready handshake plus
// the end-of-frame pulse.
interface filter_core_mc_if #(
   parameter int CHW   = 2,
   parameter int OUT_W = 32
);
   logic                    out_valid;
   logic                    out_ready;
   logic [CHW-1:0]          out_ch;
   logic signed [OUT_W-1:0] filtered;
   logic                    done;

   modport master(output out_valid, out_ch, filtered, done, input out_ready);
   modport slave (input out_valid, out_ch, filtered, done, output out_ready);
endinterface

// File: rtl/sync_n.sv
// sync_n: W-bit two-flop synchronizer for asynchronous inputs.
module sync_n #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] m_q;

   always_ff @(posedge clk)
      if (reset) {q, m_q} <= '0;
      else {q, m_q} <= {m_q, d};
endmodule

// File: rtl/filter_core_mc.sv
// filter_core_mc: multi-channel decimating barcode FIR sharing one MAC engine.
// Define FILTER_OVERRUN_EN to get a sticky flag for dropped frames.
module filter_core_mc
   import filter_pkg::*;
#(
   parameter int N_CH     = 4,
   parameter int TAPS     = 32,
   parameter int DECIM    = 8,
   parameter int COEF_W   = 16,
   parameter int OUT_W    = 32,
   parameter int COEF_SET = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_CH-1:0]  signal,
   input  logic             sample,
   filter_core_mc_if.master out_if,
   output logic             overrun
);
   localparam int ACC_W = acc_w(COEF_W, TAPS);
   localparam int CHW   = ch_w(N_CH);
   localparam int TW    = $clog2(TAPS);
   localparam int DW    = DECIM > 1 ? $clog2(DECIM) : 1;

   logic [N_CH-1:0]          s;
   logic [TAPS-1:0]          hist_q [N_CH];
   logic [TAPS-1:0]          hist_d [N_CH];
   logic [TAPS-1:0]          snap_q [N_CH];
   logic [DW-1:0]            dcnt_q;
   logic [CHW-1:0]           ch_q;
   logic [TW-1:0]            tap_q;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [COEF_W-1:0] coef [TAPS];
   logic signed [COEF_W-1:0] term;
   logic                     epoch;
   state_t                   state_q;

   sync_n #(.W(N_CH)) u_sync (.clk(clk), .reset(reset), .d(signal), .q(s));

   for (genvar k = 0; k < TAPS; k++) begin : g_coef
      assign coef[k] = COEF_SET == 1 ? COEF_W'(k + 1) : COEF_W'(LP_COEFS[k]);
   end

   always_comb
      for (int c = 0; c < N_CH; c++) hist_d[c] = {hist_q[c][TAPS-2:0], s[c]};

   assign epoch = sample && dcnt_q == DW'(DECIM - 1);
   assign term  = snap_q[ch_q][tap_q] ? coef[tap_q] : '0;
   assign acc_d = acc_q + ACC_W'(term);

   always_ff @(posedge clk) begin
      if (reset) begin
         hist_q           <= '{default: '0};
         snap_q           <= '{default: '0};
         dcnt_q           <= '0;
         ch_q             <= '0;
         tap_q            <= '0;
         acc_q            <= '0;
         state_q          <= IDLE;
         out_if.out_valid <= 1'b0;
         out_if.out_ch    <= '0;
         out_if.filtered  <= '0;
         out_if.done      <= 1'b0;
      end else begin
         out_if.done <= 1'b0;
         if (sample) begin
            hist_q <= hist_d;
            dcnt_q <= dcnt_q == DW'(DECIM - 1) ? '0 : dcnt_q + 1'b1;
         end
         // epochs seen outside IDLE are dropped: no snapshot, no output
         case (state_q)
            IDLE: if (epoch) begin
               snap_q  <= hist_d;
               ch_q    <= '0;
               tap_q   <= '0;
               acc_q   <= '0;
               state_q <= MAC;
            end
            MAC: if (tap_q == TW'(TAPS - 1)) begin
               out_if.filtered  <= OUT_W'(acc_d);
               out_if.out_ch    <= ch_q;
               out_if.out_valid <= 1'b1;
               state_q          <= HOLD;
            end else begin
               acc_q <= acc_d;
               tap_q <= tap_q + 1'b1;
            end
            HOLD: if (out_if.out_ready) begin
               out_if.out_valid <= 1'b0;
               if (ch_q == CHW'(N_CH - 1)) begin
                  out_if.done <= 1'b1;
                  state_q     <= IDLE;
               end else begin
                  ch_q    <= ch_q + 1'b1;
                  tap_q   <= '0;
                  acc_q   <= '0;
                  state_q <= MAC;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef FILTER_OVERRUN_EN
   always_ff @(posedge clk)
      overrun <= reset ? 1'b0 : overrun | (epoch && state_q != IDLE);
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_filter_core_mc.sv
// tb_filter_core_mc: directed bench; a frame-level model scores every cycle of the
// main instance, a DECIM=1 instance checks the impulse response.
module tb_filter_core_mc;
   localparam int N_CH  = 2;
   localparam int TAPS  = 4;
   localparam int DECIM = 4;
   localparam int OUT_W = 32;
`ifdef FILTER_OVERRUN_EN
   localparam bit OV_EN = 1'b1;
`else
   localparam bit OV_EN = 1'b0;
`endif

   typedef struct {int ch; int val;} res_t;

   logic       clk = 1'b0, reset = 1'b1, sample = 1'b0, sample2 = 1'b0;
   logic [1:0] signal = '0, signal2 = '0;
   logic       overrun, overrun2;
   int         tests = 0, fails = 0, done_cnt = 0;

   res_t expq[$], log1[$], log2[$];
   int   exp_v[$];
   bit   hist [N_CH][TAPS];
   int   dcnt, pending, cnt;
   bit   v_exp, d_exp, ov_exp, rst_chk;

   always #5 clk = ~clk;

   filter_core_mc_if #(.CHW(1), .OUT_W(OUT_W)) bus ();
   filter_core_mc_if #(.CHW(1), .OUT_W(OUT_W)) bus2 ();

   filter_core_mc #(.N_CH(N_CH), .TAPS(TAPS), .DECIM(DECIM), .COEF_W(16), .OUT_W(OUT_W), .COEF_SET(1)) dut (
      .clk(clk), .reset(reset), .signal(signal), .sample(sample), .out_if(bus), .overrun(overrun));

   filter_core_mc #(.N_CH(N_CH), .TAPS(TAPS), .DECIM(1), .COEF_W(16), .OUT_W(OUT_W), .COEF_SET(1)) dut2 (
      .clk(clk), .reset(reset), .signal(signal2), .sample(sample2), .out_if(bus2), .overrun(overrun2));

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Ramp coefficients COEF[k] = k+1 applied to newest-first sampled bits
   function automatic int y(input int c);
      int acc = 0;
      for (int k = 0; k < TAPS; k++) if (hist[c][k]) acc += k + 1;
      return acc;
   endfunction

   // Frame-level model: strobes fill histories, every DECIM-th strobe is an epoch
   // that is taken only if no earlier frame is still pending.
   always @(negedge clk) begin
      bit v_n, d_n;
      if (reset) begin
         hist = '{default: 0};
         dcnt = 0; pending = 0; cnt = 0;
         expq.delete();
         v_exp = 0; d_exp = 0; ov_exp = 0; rst_chk = 1;
      end else begin
         chk("valid", bus.out_valid, v_exp);
         chk("done", bus.done, d_exp);
         chk("overrun", overrun, ov_exp);
         if (rst_chk) begin
            chk("rst_filtered", bus.filtered, 0);
            chk("rst_out_ch", bus.out_ch, 0);
            rst_chk = 0;
         end
         if (v_exp && expq.size() > 0) begin
            chk("out_ch", bus.out_ch, expq[0].ch);
            chk("filtered", bus.filtered, expq[0].val);
         end
         if (bus.done) done_cnt++;
         v_n = v_exp;
         d_n = 0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) v_n = 1;
         end
         if (sample) begin
            for (int c = 0; c < N_CH; c++) begin
               for (int k = TAPS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
               hist[c][0] = signal[c];
            end
            dcnt++;
            if (dcnt == DECIM) begin
               dcnt = 0;
               if (pending == 0) begin
                  for (int c = 0; c < N_CH; c++) expq.push_back('{c, y(c)});
                  pending = N_CH;
                  cnt = TAPS;
               end else ov_exp |= OV_EN;
            end
         end
         if (v_exp && bus.out_ready) begin
            log1.push_back('{int'(bus.out_ch), int'(bus.filtered)});
            if (expq.size() > 0) void'(expq.pop_front());
            pending--;
            v_n = 0;
            if (pending == 0) d_n = 1;
            else cnt = TAPS;
         end
         v_exp = v_n;
         d_exp = d_n;
      end
   end

   always @(negedge clk)
      if (!reset && bus2.out_valid && bus2.out_ready)
         log2.push_back('{int'(bus2.out_ch), int'(bus2.filtered)});

   task automatic strobe(input logic [1:0] b);
      signal = b;
      repeat (3) @(posedge clk);
      #1 sample = 1'b1;
      @(posedge clk);
      #1 sample = 1'b0;
   endtask

   task automatic strobe2(input logic [1:0] b);
      signal2 = b;
      repeat (3) @(posedge clk);
      #1 sample2 = 1'b1;
      @(posedge clk);
      #1 sample2 = 1'b0;
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Compare accepted results (channels alternate 0,1) with literal expectations
   task automatic chk_log(input string nm);
      chk({nm, "_count"}, log1.size(), exp_v.size());
      for (int i = 0; i < exp_v.size() && i < log1.size(); i++) begin
         chk({nm, "_ch"}, log1[i].ch, i % 2);
         chk({nm, "_val"}, log1[i].val, exp_v[i]);
      end
      log1.delete();
   endtask

   initial begin
      int n, d0;
      logic signed [OUT_W-1:0] f0;
      logic c0;
      bit stable;
      bus.out_ready = 1'b1;
      bus2.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      // all ones, two frames
      d0 = done_cnt;
      repeat (8) strobe(2'b11);
      idle(20);
      exp_v = {10, 10, 10, 10};
      chk_log("ones");
      chk("ones_done_pulses", done_cnt - d0, 2);
      // single newest bit on ch0
      strobe(2'b00); strobe(2'b00); strobe(2'b00); strobe(2'b01);
      idle(20);
      exp_v = {1, 0};
      chk_log("newest");
      // backpressure
      bus.out_ready = 1'b0;
      strobe(2'b01); strobe(2'b10); strobe(2'b01); strobe(2'b01);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(posedge clk);
         #1 n++;
      end
      chk("bp_valid_seen", bus.out_valid, 1);
      f0 = bus.filtered;
      c0 = bus.out_ch;
      stable = 1;
      repeat (20) begin
         @(negedge clk);
         if (!bus.out_valid || bus.filtered !== f0 || bus.out_ch !== c0) stable = 0;
      end
      chk("bp_stable", stable, 1);
      chk("bp_hold_val", f0, 7);
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      idle(20);
      exp_v = {7, 3};
      chk_log("bp");
      // overrun: epoch while held in HOLD is dropped
      bus.out_ready = 1'b0;
      strobe(2'b11); strobe(2'b01); strobe(2'b01); strobe(2'b01);
      repeat (4) strobe(2'b00);
      bus.out_ready = 1'b1;
      idle(20);
      exp_v = {10, 4};
      chk_log("drop");
      chk("drop_overrun", overrun, OV_EN);
      // reset during MAC of ch1, dcnt mid-count
      repeat (4) strobe(2'b11);
      strobe(2'b11);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      exp_v = {10};
      chk_log("pre_rst");
      @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_filt", bus.filtered, 0);
      chk("rst_overrun", overrun, 0);
      @(posedge clk);
      #1;
      repeat (4) strobe(2'b11);
      idle(20);
      exp_v = {10, 10};
      chk_log("post_rst");
      // impulse response, DECIM=1
      strobe2(2'b01);
      repeat (4) strobe2(2'b00);
      idle(20);
      log1 = log2;
      exp_v = {1, 0, 2, 0, 3, 0, 4, 0, 0, 0};
      chk_log("impulse");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got no end, expected end");
      $fatal(1);
   end
endmodule
